console_text_controller: RTL and testbench
==========================================

// Module: console_text_controller
// PURPOSE
// - Owns the console text buffer: accepts a byte stream (chars + control codes), writes cells at a cursor, handles
//   wrap, newline, scroll and clear. Serves the console renderer's per-pixel character/attribute lookup from cx/cy.
// - Sits in the clk_pixel domain between a host byte source (SAM/NINA bridge) and the console glyph renderer.
// - Replaces the free-running character counter feeding the console.
// PARAMETERS
// - COLS          80     text columns (8-px glyph width; 640/8)
// - ROWS          30     text rows (16-px glyph height; 480/16)
// - DEFAULT_ATTR  8'h0F  attribute written by clear operations
// PORTS
// - clk_pixel      in   1   pixel clock; the only clock
// - reset          in   1   asynchronous, active-high reset
// - in_valid       in   1   host byte valid
// - in_ready       out  1   controller can accept a byte this cycle
// - in_char        in   8   byte: printable or control code
// - in_attr        in   8   attribute stored with a printable byte
// - cx, cy         in   10  current pixel coordinates from the HDMI timing core
// - character      out  8   cell character for the pixel at (cx,cy), 2-cycle latency
// - attribute      out  8   cell attribute, 2-cycle latency, aligned with character
// - cursor_col     out  $clog2(COLS)  current cursor column
// - cursor_row     out  $clog2(ROWS)  current cursor screen row
// - busy           out  1   a clear operation is in progress
// BEHAVIOUR
// - Reset: cursor_col=0, cursor_row=0, top_row=0, character=0, attribute=0, in_ready=0, busy=1;
//   FSM enters CLEAR_ALL. Reset asserted mid-operation aborts it and restarts CLEAR_ALL.
// - Handshake: byte accepted on the edge where in_valid && in_ready. in_ready=1 only in IDLE.
//   Source holds in_char/in_attr stable while in_valid && !in_ready.
// - FSM states: IDLE, CLEAR_ROW, CLEAR_ALL.
//   - IDLE, printable (0x20..0xFF): write {in_char,in_attr} at (cursor_col, phys row). Then col+1.
//     If col reaches COLS, apply newline.
//   - IDLE, 0x0A (LF): newline. 0x0D (CR): col=0.
//     0x08 (BS): col-1 if col>0, else no-op (no wrap to previous row).
//     0x0C (FF): col=0, row=0, top_row=0, then CLEAR_ALL.
//     Other codes 0x00..0x1F: ignored, no state change.
//   - Newline: col=0. If row<ROWS-1, row+1 and stay IDLE.
//     Else scroll: row stays ROWS-1, top_row=(top_row+1) mod ROWS, then CLEAR_ROW on the new bottom physical row.
//   - CLEAR_ROW: writes {0x20,DEFAULT_ATTR} to COLS cells, one per cycle (COLS cycles), then IDLE.
//   - CLEAR_ALL: same, over COLS*ROWS cells (2400 cycles at defaults), then IDLE.
//   - busy=1 exactly in CLEAR_ROW/CLEAR_ALL.
// - Physical row = (screen_row + top_row) mod ROWS. Use compare-and-subtract, no divider.
//   Scrolling never copies cells.
// - Read path (never stalled by writes):
//   - Cycle 0: sample col=cx[9:3], srow=cy[8:4], in_range=(cx<8*COLS)&&(cy<16*ROWS); compute physical address.
//   - Cycle 1: RAM read.
//   - Cycle 2: character/attribute registered; forced to 0x00/0x00 when in_range=0.
// - RAM address = phys_row*COLS + col, width $clog2(COLS*ROWS). Multiply by a constant only.
// - Read and write to the same address in one cycle: read returns old data.
// - All counters wrap strictly inside their ranges. Cursor outputs are never >= COLS/ROWS.
// STRUCTURE
// - Package console_pkg: COLS/ROWS defaults, DEFAULT_ATTR, control-code constants (LF, CR, BS, FF),
//   cell_t struct {char, attr}, FSM state enum.
// - Sub-module text_ram: simple dual-port RAM, COLS*ROWS x 16 bits.
//   One write port, one registered read port, old-data read-during-write. Infers block RAM.
// - Top: handshake, cursor/top_row registers, FSM, address pipeline, output mux.
// TESTING
// 1. Reset released -> busy=1 for 2400 cycles, in_ready=0; afterwards every in-range cell reads {0x20,0x0F}.
// 2. Send 'A' (0x41, attr 0x1E) after reset -> cell (0,0) reads 0x41/0x1E at cx=0..7,cy=0..15; cursor_col=1.
//    Check 2-cycle output latency.
// 3. Send 80 printables on row 0 -> cursor (0,1); 81st byte lands at (0,1). Then BS at col 0 -> no change.
// 4. Fill to row 29 and send LF -> top_row=1, busy=1 for 80 cycles, screen row 0 shows former row 1,
//    row 29 blank, cursor (0,29).
// 5. Send FF mid-screen -> cursor (0,0), 2400-cycle clear, all cells blank; cx=640 or cy=480 -> 0x00/0x00.
// 6. Assert reset during CLEAR_ROW and while in_valid is held -> FSM restarts CLEAR_ALL, no byte accepted
//    until busy=0, held byte accepted exactly once.

Source files
------------

// File: rtl/console_pkg.sv
// Shared definitions for the console text controller: geometry defaults,
// control codes, cell layout and controller states.
package console_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;
  localparam logic [7:0] DEF_ATTR = 8'h0F;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] attr;
  } cell_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ROW = 2'd1,
    CLEAR_ALL = 2'd2
  } state_t;

endpackage

// File: rtl/console_text_controller_text_ram.sv
// Simple dual-port text buffer: one write port, one registered read port
// returning the previous contents when both ports hit the same cell.
module text_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12,
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/console_text_controller.sv
// Console text buffer controller: byte stream in, cursor/scroll/clear handling,
// and a 2-cycle character/attribute lookup for the glyph renderer.
module console_text_controller
  import console_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter logic [7:0] DEFAULT_ATTR = DEF_ATTR
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_char,
  input  logic [7:0]              in_attr,
  input  logic [9:0]              cx,
  input  logic [9:0]              cy,
  output logic [7:0]              character,
  output logic [7:0]              attribute,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic                    busy
);

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0]    ROWS_WIDE  = (ROW_W + 1)'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ROW_LEFT   = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ALL_LEFT   = ADDR_W'(CELLS - 1);

  // Screen row to physical row: the buffer is a ring rotated by top_row.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] srow,
                                                input logic [ROW_W-1:0] top);
    logic [ROW_W:0] sum;
    sum = {1'b0, srow} + {1'b0, top};
    if (sum >= ROWS_WIDE) sum = sum - ROWS_WIDE;
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(prow) * COLS_A + ADDR_W'(col);
  endfunction

  state_t              state_reg, state_next;
  logic [COL_W-1:0]    col_reg, col_next;
  logic [ROW_W-1:0]    row_reg, row_next;
  logic [ROW_W-1:0]    top_reg, top_next;
  logic [ADDR_W-1:0]   clr_addr_reg, clr_addr_next;
  logic [ADDR_W-1:0]   clr_left_reg, clr_left_next;
  logic                newline;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  cell_t               wr_cell;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_reg    <= CLEAR_ALL;
      col_reg      <= '0;
      row_reg      <= '0;
      top_reg      <= '0;
      clr_addr_reg <= '0;
      clr_left_reg <= ALL_LEFT;
    end else begin
      state_reg    <= state_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      top_reg      <= top_next;
      clr_addr_reg <= clr_addr_next;
      clr_left_reg <= clr_left_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    row_next      = row_reg;
    top_next      = top_reg;
    clr_addr_next = clr_addr_reg;
    clr_left_next = clr_left_reg;
    newline       = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = clr_addr_reg;
    wr_cell       = '{ch: BLANK_CHAR, attr: DEFAULT_ATTR};
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (in_char >= BLANK_CHAR) begin
            wr_en   = 1'b1;
            wr_addr = cell_addr(phys_row(row_reg, top_reg), col_reg);
            wr_cell = '{ch: in_char, attr: in_attr};
            if (col_reg == COL_LAST) newline = 1'b1;
            else col_next = col_reg + COL_W'(1);
          end else begin
            case (in_char)
              CH_LF: newline = 1'b1;
              CH_CR: col_next = '0;
              CH_BS: if (col_reg != '0) col_next = col_reg - COL_W'(1);
              CH_FF: begin
                col_next      = '0;
                row_next      = '0;
                top_next      = '0;
                clr_addr_next = '0;
                clr_left_next = ALL_LEFT;
                state_next    = CLEAR_ALL;
              end
              default: ;
            endcase
          end
          if (newline) begin
            col_next = '0;
            if (row_reg != ROW_LAST) begin
              row_next = row_reg + ROW_W'(1);
            end else begin
              // After the scroll the new bottom physical row is the old top row.
              top_next      = (top_reg == ROW_LAST) ? '0 : top_reg + ROW_W'(1);
              clr_addr_next = cell_addr(top_reg, '0);
              clr_left_next = ROW_LEFT;
              state_next    = CLEAR_ROW;
            end
          end
        end
      end
      CLEAR_ROW, CLEAR_ALL: begin
        wr_en = 1'b1;
        if (clr_left_reg == '0) begin
          state_next = IDLE;
        end else begin
          clr_addr_next = clr_addr_reg + ADDR_W'(1);
          clr_left_next = clr_left_reg - ADDR_W'(1);
        end
      end
      default: begin
        clr_addr_next = '0;
        clr_left_next = ALL_LEFT;
        state_next    = CLEAR_ALL;
      end
    endcase
  end

  assign in_ready   = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign cursor_col = col_reg;
  assign cursor_row = row_reg;

  logic [COL_W-1:0]  rd_col;
  logic [ROW_W-1:0]  rd_srow;
  logic              rd_in_range;
  logic              in_range_d;
  logic [ADDR_W-1:0] rd_addr;
  cell_t             rd_cell;

  assign rd_in_range = (cx < 10'(8 * COLS)) && (cy < 10'(16 * ROWS));
  assign rd_col      = COL_W'(cx >> 3);
  assign rd_srow     = ROW_W'(cy >> 4);
  // Off-screen pixels read cell 0; the output stage blanks them anyway.
  assign rd_addr     = rd_in_range ? cell_addr(phys_row(rd_srow, top_reg), rd_col) : '0;

  text_ram #(
    .DEPTH (CELLS),
    .AW    (ADDR_W),
    .W     (16)
  ) u_text_ram (
    .clk   (clk_pixel),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_cell),
    .raddr (rd_addr),
    .rdata (rd_cell)
  );

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      in_range_d <= 1'b0;
      character  <= '0;
      attribute  <= '0;
    end else begin
      in_range_d <= rd_in_range;
      character  <= in_range_d ? rd_cell.ch : 8'h00;
      attribute  <= in_range_d ? rd_cell.attr : 8'h00;
    end
  end

endmodule

// File: tb/tb_console_text_controller.sv
// Randomized bench for console_text_controller against a screen-level model
// that shifts rows on scroll and clears instantly.
module tb_console_text_controller;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic [7:0] in_attr = 8'h00;
  logic [9:0] cx, cy;
  logic       in_ready, busy;
  logic [7:0] character, attribute;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;

  logic       rand_xy = 1'b0;
  logic [9:0] man_cx = '0, man_cy = '0, rnd_cx = '0, rnd_cy = '0;
  assign cx = rand_xy ? rnd_cx : man_cx;
  assign cy = rand_xy ? rnd_cy : man_cy;

  always #5 clk = ~clk;

  console_text_controller dut (
    .clk_pixel  (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_attr    (in_attr),
    .cx         (cx),
    .cy         (cy),
    .character  (character),
    .attribute  (attribute),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Screen model indexed by screen row; scrolling really moves rows here.
  logic [15:0] scr [ROWS][COLS];
  int m_col, m_row, m_busy;

  function automatic void blank_row(input int r);
    for (int c = 0; c < COLS; c++) scr[r][c] = 16'h200F;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++) blank_row(r);
    m_col = 0;
    m_row = 0;
    m_busy = ROWS * COLS;
  endfunction

  function automatic void model_newline();
    m_col = 0;
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      blank_row(ROWS - 1);
      m_busy = COLS;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] c, input logic [7:0] a);
    if (c >= 8'h20) begin
      scr[m_row][m_col] = {c, a};
      m_col++;
      if (m_col == COLS) model_newline();
    end else if (c == 8'h0A) model_newline();
    else if (c == 8'h0D) m_col = 0;
    else if (c == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (c == 8'h0C) model_clear();
  endfunction

  function automatic logic [15:0] model_pixel(input int x, input int y);
    if (x < 8 * COLS && y < 16 * ROWS) return scr[y / 16][x / 8];
    return 16'h0000;
  endfunction

  initial model_clear();

  logic [15:0] pipe_val = '0;
  logic        pipe_ok = 1'b0;

  always begin
    logic [15:0] prev_val;
    logic        prev_ok;
    @(posedge clk);
    prev_val = pipe_val;
    prev_ok  = pipe_ok;
    if (reset) begin
      model_clear();
      pipe_ok = 1'b0;
    end else begin
      pipe_ok  = (m_busy == 0);
      pipe_val = model_pixel(int'(cx), int'(cy));
      if (m_busy > 0) m_busy--;
      else if (in_valid) model_byte(in_char, in_attr);
    end
    #1;
    chk("in_ready", int'(in_ready), int'(!reset && m_busy == 0));
    chk("busy", int'(busy), int'(reset || m_busy != 0));
    chk("cursor_col", int'(cursor_col), m_col);
    chk("cursor_row", int'(cursor_row), m_row);
    if (reset) begin
      chk("char_reset", int'(character), 0);
      chk("attr_reset", int'(attribute), 0);
    end else if (prev_ok) begin
      chk("character", int'(character), int'(prev_val[15:8]));
      chk("attribute", int'(attribute), int'(prev_val[7:0]));
    end
  end

  always @(negedge clk) begin
    rnd_cx = 10'($urandom_range(0, 700));
    rnd_cy = 10'($urandom_range(0, 520));
  end

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = c;
    in_attr  = a;
    while (in_ready !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", int'(n >= 6000), 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 6000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic look(input int x, input int y);
    @(negedge clk);
    man_cx = 10'(x);
    man_cy = 10'(y);
    @(posedge clk);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] b;
    int r;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    count_busy(n);
    chk("clear_all_len", n, 2400);
    look(17, 40);
    chk("blank_char", int'(character), 8'h20);
    chk("blank_attr", int'(attribute), 8'h0F);

    look(100, 0);
    send(8'h41, 8'h1E);
    @(negedge clk);
    man_cx = 10'd3;
    man_cy = 10'd5;
    @(posedge clk); #2;
    chk("latency_1cyc_char", int'(character), 8'h20);
    @(posedge clk); #2;
    chk("latency_2cyc_char", int'(character), 8'h41);
    chk("latency_2cyc_attr", int'(attribute), 8'h1E);
    chk("col_after_A", int'(cursor_col), 1);

    send(8'h0D, 8'h00);
    for (int i = 0; i < COLS; i++) send(8'(97 + i % 26), 8'h07);
    chk("wrap_col", int'(cursor_col), 0);
    chk("wrap_row", int'(cursor_row), 1);
    send(8'h51, 8'h2A);
    chk("byte81_col", int'(cursor_col), 1);
    chk("byte81_row", int'(cursor_row), 1);
    send(8'h0D, 8'h00);
    send(8'h08, 8'h00);
    chk("bs_col0_col", int'(cursor_col), 0);
    chk("bs_col0_row", int'(cursor_row), 1);

    for (int i = 0; i < 40 && m_row < ROWS - 1; i++) send(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    count_busy(n);
    chk("scroll_len", n, 80);
    chk("scroll_cursor_row", int'(cursor_row), 29);
    chk("scroll_cursor_col", int'(cursor_col), 0);
    look(2, 3);
    chk("scrolled_char", int'(character), 8'h51);
    chk("scrolled_attr", int'(attribute), 8'h2A);
    look(5, 29 * 16 + 7);
    chk("new_bottom_char", int'(character), 8'h20);

    repeat (3) send(8'h4D, 8'h11);
    send(8'h0C, 8'h00);
    count_busy(n);
    chk("ff_clear_len", n, 2400);
    chk("ff_col", int'(cursor_col), 0);
    chk("ff_row", int'(cursor_row), 0);
    look(640, 0);
    chk("cx640_char", int'(character), 0);
    chk("cx640_attr", int'(attribute), 0);
    look(0, 480);
    chk("cy480_char", int'(character), 0);
    look(8, 16);
    chk("ff_blank_char", int'(character), 8'h20);

    repeat (ROWS - 1) send(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    chk("in_clear_row", int'(busy), 1);
    in_valid = 1'b1;
    in_char  = 8'h5A;
    in_attr  = 8'h33;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    count_busy(n);
    chk("reset_clear_len", n, 2400);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("held_once_col", int'(cursor_col), 1);
    chk("held_once_row", int'(cursor_row), 0);
    look(0, 0);
    chk("held_char", int'(character), 8'h5A);
    chk("held_attr", int'(attribute), 8'h33);

    rand_xy = 1'b1;
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) b = 8'($urandom_range(32, 255));
      else if (r < 82) b = 8'h0A;
      else if (r < 87) b = 8'h0D;
      else if (r < 93) b = 8'h08;
      else if (r < 95) b = 8'h0C;
      else b = 8'($urandom_range(0, 31));
      send(b, 8'($urandom));
    end
    count_busy(n);
    chk("final_idle", int'(n < 6000), 1);
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
